// File: rtl/lzrw1_pkg.sv
// Shared types and helpers for the LZRW1 stream sequencer.
package lzrw1_pkg;

    typedef enum logic [2:0] {IDLE, CW0, CW1, B0, B1, ISSUE, FIN} state_t;

    localparam int   CW_BYTES     = 2;
    localparam logic LITERAL_FLAG = 1'b0;
    localparam logic COPY_FLAG    = 1'b1;

    // Item flags are taken MSB-first: item 0 is governed by cw[15].
    function automatic logic cw_flag(input logic [15:0] cw, input logic [3:0] idx);
        return cw[4'd15 - idx];
    endfunction

endpackage

// File: rtl/lzrw1_stream_sequencer.sv
// Parses a raw LZRW1 byte stream into literal/copy items for the decompressor,
// one item outstanding at a time, with job length tracking and truncation detection.
module lzrw1_stream_sequencer
    import lzrw1_pkg::*;
#(
    parameter int LEN_WIDTH    = 16,
    parameter int ITEMS_PER_CW = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic [LEN_WIDTH-1:0] comp_len,
    input  logic [7:0]           in_byte,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [15:0]          dec_data,
    output logic                 dec_control_word,
    output logic                 dec_data_valid,
    input  logic                 dec_busy,
    output logic                 seq_busy,
    output logic                 done,
    output logic                 error
);

    localparam logic [3:0]           LAST_IDX = 4'(ITEMS_PER_CW - 1);
    localparam logic [LEN_WIDTH-1:0] ONE      = LEN_WIDTH'(1);

    state_t                state_q, state_d;
    logic [LEN_WIDTH-1:0]  rem_q, rem_d;
    logic [3:0]            item_idx_q, item_idx_d;
    logic [15:0]           cw_q, cw_d;
    logic [7:0]            hold_q, hold_d;
    logic [15:0]           dec_data_q, dec_data_d;
    logic                  dec_cw_q, dec_cw_d;
    logic                  dec_valid_q, dec_valid_d;
    logic                  in_ready_q, in_ready_d;
    logic                  seq_busy_q, seq_busy_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;
    logic                  byte_xfer, item_xfer;

    assign byte_xfer = in_valid && in_ready_q;
    assign item_xfer = dec_valid_q && !dec_busy;

    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        item_idx_d  = item_idx_q;
        cw_d        = cw_q;
        hold_d      = hold_q;
        dec_data_d  = dec_data_q;
        dec_cw_d    = dec_cw_q;
        dec_valid_d = dec_valid_q;
        error_d     = error_q;
        done_d      = (state_q == FIN);

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    error_d = 1'b0;
                    rem_d   = comp_len;
                    state_d = (comp_len == '0) ? FIN : CW0;
                end
            end
            CW0: begin
                if (byte_xfer) begin
                    cw_d[15:8] = in_byte;
                    rem_d      = rem_q - ONE;
                    if (rem_q == ONE) begin
                        error_d = 1'b1;
                        state_d = FIN;
                    end else begin
                        state_d = CW1;
                    end
                end
            end
            CW1: begin
                if (byte_xfer) begin
                    cw_d[7:0]  = in_byte;
                    item_idx_d = 4'd0;
                    rem_d      = rem_q - ONE;
                    // A control word closing the stream is legal: it simply governs no items.
                    state_d    = (rem_q == ONE) ? FIN : B0;
                end
            end
            B0: begin
                if (byte_xfer) begin
                    rem_d = rem_q - ONE;
                    if (cw_flag(cw_q, item_idx_q) == LITERAL_FLAG) begin
                        dec_data_d  = {8'h00, in_byte};
                        dec_cw_d    = LITERAL_FLAG;
                        dec_valid_d = 1'b1;
                        state_d     = ISSUE;
                    end else begin
                        hold_d = in_byte;
                        if (rem_q == ONE) begin
                            error_d = 1'b1;
                            state_d = FIN;
                        end else begin
                            state_d = B1;
                        end
                    end
                end
            end
            B1: begin
                if (byte_xfer) begin
                    rem_d       = rem_q - ONE;
                    dec_data_d  = {hold_q, in_byte};
                    dec_cw_d    = COPY_FLAG;
                    dec_valid_d = 1'b1;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                if (item_xfer) begin
                    dec_valid_d = 1'b0;
                    if (rem_q == '0) begin
                        state_d = FIN;
                    end else if (item_idx_q == LAST_IDX) begin
                        state_d = CW0;
                    end else begin
                        item_idx_d = item_idx_q + 4'd1;
                        state_d    = B0;
                    end
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Handshake flags are registered from the next state so they align with state_q.
        in_ready_d = (state_d == CW0) || (state_d == CW1) || (state_d == B0) || (state_d == B1);
        seq_busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            rem_q       <= '0;
            item_idx_q  <= '0;
            cw_q        <= '0;
            hold_q      <= '0;
            dec_data_q  <= '0;
            dec_cw_q    <= 1'b0;
            dec_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
            seq_busy_q  <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            item_idx_q  <= item_idx_d;
            cw_q        <= cw_d;
            hold_q      <= hold_d;
            dec_data_q  <= dec_data_d;
            dec_cw_q    <= dec_cw_d;
            dec_valid_q <= dec_valid_d;
            in_ready_q  <= in_ready_d;
            seq_busy_q  <= seq_busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    assign in_ready         = in_ready_q;
    assign dec_data         = dec_data_q;
    assign dec_control_word = dec_cw_q;
    assign dec_data_valid   = dec_valid_q;
    assign seq_busy         = seq_busy_q;
    assign done             = done_q;
    assign error            = error_q;

endmodule

// File: tb/tb_lzrw1_stream_sequencer.sv
// Directed bench for lzrw1_stream_sequencer: feeds hand-built LZRW1 streams and
// compares issued items, done/error behaviour and reset response with expected values.
module tb_lzrw1_stream_sequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [15:0] comp_len = '0;
    logic [7:0]  in_byte = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] dec_data;
    logic        dec_control_word;
    logic        dec_data_valid;
    logic        dec_busy = 1'b0;
    logic        seq_busy;
    logic        done;
    logic        error;

    lzrw1_stream_sequencer #(.LEN_WIDTH(16), .ITEMS_PER_CW(16)) dut (
        .clock(clock), .reset(reset), .start(start), .comp_len(comp_len),
        .in_byte(in_byte), .in_valid(in_valid), .in_ready(in_ready),
        .dec_data(dec_data), .dec_control_word(dec_control_word),
        .dec_data_valid(dec_data_valid), .dec_busy(dec_busy),
        .seq_busy(seq_busy), .done(done), .error(error)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    logic [7:0]  bq[$];
    logic [16:0] got[$];
    logic [16:0] expq[$];
    int done_cnt, unstable, bad_drop, overlap, consumed;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cmp_items(input string tag);
        int n;
        chk({tag, "_count"}, got.size(), expq.size());
        n = (got.size() < expq.size()) ? got.size() : expq.size();
        for (int i = 0; i < n; i++)
            chk($sformatf("%s_item%0d", tag, i), 32'(got[i]), 32'(expq[i]));
    endtask

    // Runs one job: bytes from bq, each item held busy for busy_hold cycles.
    task automatic run_job(input logic [15:0] len, input int busy_hold, input bit gap);
        int   bl, tail;
        bit   pend, just;
        logic [15:0] hd;
        logic hc;
        got.delete();
        done_cnt = 0; unstable = 0; bad_drop = 0; overlap = 0; consumed = 0;
        bl = 0; tail = 0; pend = 0; just = 0; hd = '0; hc = 1'b0;
        @(negedge clock);
        start = 1'b1; comp_len = len; in_valid = 1'b0; dec_busy = 1'b0;
        @(negedge clock);
        start = 1'b0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (done) done_cnt++;
            if (dec_data_valid && in_ready) overlap++;
            if (just && dec_data_valid) bad_drop++;
            just = 0;
            if (consumed < bq.size() && (!gap || $urandom_range(0, 2) != 0)) begin
                in_valid = 1'b1;
                in_byte  = bq[consumed];
            end else begin
                in_valid = 1'b0;
                in_byte  = 8'($urandom_range(0, 255));
            end
            if (in_valid && in_ready) consumed++;
            if (dec_data_valid) begin
                if (!pend) begin
                    pend = 1; bl = busy_hold; hd = dec_data; hc = dec_control_word;
                end else if (dec_data !== hd || dec_control_word !== hc) begin
                    unstable++;
                end
                if (bl > 0) begin
                    dec_busy = 1'b1;
                    bl--;
                end else begin
                    dec_busy = 1'b0;
                    got.push_back({hc, hd});
                    pend = 0;
                    just = 1;
                end
            end else begin
                pend = 0;
                dec_busy = 1'($urandom_range(0, 1));
            end
            if (done_cnt > 0) tail++;
            if (tail > 3) break;
            @(negedge clock);
        end
        in_valid = 1'b0;
        dec_busy = 1'b0;
    endtask

    initial begin
        // Reset state
        #3;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_dec_data", dec_data, 0);
        chk("rst_dec_valid", dec_data_valid, 0);
        chk("rst_dec_cw", dec_control_word, 0);
        chk("rst_seq_busy", seq_busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        @(negedge clock);
        reset = 1'b1;

        // Literal job
        bq = '{8'h00, 8'h00, 8'h41, 8'h42};
        expq = '{17'h00041, 17'h00042};
        run_job(16'd4, 0, 1'b0);
        cmp_items("lit");
        chk("lit_done_cnt", done_cnt, 1);
        chk("lit_error", error, 0);
        chk("lit_consumed", consumed, 4);
        chk("lit_overlap", overlap, 0);
        chk("lit_idle", seq_busy, 0);

        // Copy item with busy held
        bq = '{8'h40, 8'h00, 8'h41, 8'hF0, 8'h03};
        expq = '{17'h00041, 17'h1F003};
        run_job(16'd5, 5, 1'b0);
        cmp_items("copy");
        chk("copy_done_cnt", done_cnt, 1);
        chk("copy_error", error, 0);
        chk("copy_unstable", unstable, 0);
        chk("copy_drop", bad_drop, 0);

        // Control-word rollover: 16 literals, second cw, 1 literal
        bq.delete(); expq.delete();
        bq.push_back(8'h00); bq.push_back(8'h00);
        for (int k = 0; k < 16; k++) begin
            bq.push_back(8'(8'h10 + k));
            expq.push_back({9'h000, 8'(8'h10 + k)});
        end
        bq.push_back(8'h00); bq.push_back(8'h00); bq.push_back(8'hAB);
        expq.push_back(17'h000AB);
        run_job(16'd21, 0, 1'b0);
        cmp_items("roll");
        chk("roll_done_cnt", done_cnt, 1);
        chk("roll_consumed", consumed, 21);
        chk("roll_error", error, 0);

        // Same stream with gapped upstream valid
        run_job(16'd21, 1, 1'b1);
        cmp_items("gap");
        chk("gap_done_cnt", done_cnt, 1);
        chk("gap_consumed", consumed, 21);

        // Truncated copy
        bq = '{8'h80, 8'h00, 8'h55};
        expq.delete();
        run_job(16'd3, 0, 1'b0);
        chk("trunc_items", got.size(), 0);
        chk("trunc_error", error, 1);
        chk("trunc_done_cnt", done_cnt, 1);
        chk("trunc_consumed", consumed, 3);

        // Next start clears error
        bq = '{8'h00, 8'h00, 8'h41, 8'h42};
        expq = '{17'h00041, 17'h00042};
        run_job(16'd4, 2, 1'b0);
        chk("clr_error", error, 0);
        cmp_items("clr");

        // comp_len = 0
        @(negedge clock);
        start = 1'b1; comp_len = 16'd0;
        @(negedge clock);
        start = 1'b0;
        chk("zero_done_c1", done, 0);
        chk("zero_busy_c1", seq_busy, 1);
        chk("zero_rdy_c1", in_ready, 0);
        @(negedge clock);
        chk("zero_done_c2", done, 1);
        chk("zero_rdy_c2", in_ready, 0);
        @(negedge clock);
        chk("zero_done_c3", done, 0);

        // Async reset while in ISSUE
        consumed = 0;
        @(negedge clock);
        start = 1'b1; comp_len = 16'd4;
        @(negedge clock);
        start = 1'b0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            if (dec_data_valid) break;
            in_valid = (consumed < bq.size());
            in_byte  = in_valid ? bq[consumed] : 8'h00;
            if (in_valid && in_ready) consumed++;
            dec_busy = 1'b1;
            @(negedge clock);
        end
        in_valid = 1'b0;
        dec_busy = 1'b1;
        chk("arst_pre_valid", dec_data_valid, 1);
        #2 reset = 1'b0;
        #1;
        chk("arst_valid", dec_data_valid, 0);
        chk("arst_data", dec_data, 0);
        chk("arst_busy", seq_busy, 0);
        chk("arst_done", done, 0);
        @(negedge clock);
        reset = 1'b1;
        dec_busy = 1'b0;
        done_cnt = 0;
        for (int cyc = 0; cyc < 4; cyc++) begin
            @(negedge clock);
            if (done) done_cnt++;
        end
        chk("arst_no_done", done_cnt, 0);

        // New job after reset
        bq = '{8'h40, 8'h00, 8'h41, 8'hF0, 8'h03};
        expq = '{17'h00041, 17'h1F003};
        run_job(16'd5, 0, 1'b0);
        cmp_items("post");
        chk("post_done_cnt", done_cnt, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lzrw1_stream_sequencer.md
Name: lzrw1_stream_sequencer

Overview:
- Front-end controller for decompressor_top. Accepts a raw LZRW1 compressed byte stream from an upstream byte source (DMA or FIFO) using a valid/ready handshake.
- Parses each 16-bit control word and assembles literal and copy items. Issues them one at a time as a 16-bit data word plus a control bit, respecting the decompressor busy signal.
- Tracks the job byte count and signals done or error.

Parameters:
- LEN_WIDTH, 16, width of the compressed-length counter (maximum job of 2^LEN_WIDTH-1 bytes).
- ITEMS_PER_CW, 16, number of items governed by one control word (must be 16 for LZRW1; exposed for test only).

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; begins a job; ignored unless state is IDLE
- comp_len  in  LEN_WIDTH  total compressed bytes in the job; sampled on start
- in_byte  in  8  upstream compressed byte
- in_valid  in  1  in_byte is valid
- in_ready  out  1  sequencer accepts in_byte this cycle
- dec_data  out  16  item word to decompressor data_in
- dec_control_word  out  1  item flag (0 = literal, 1 = copy)
- dec_data_valid  out  1  item presented to decompressor
- dec_busy  in  1  decompressor_busy
- seq_busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at job end (normal or error)
- error  out  1  sticky; set on truncated stream; cleared by next start

Behaviour:
- Reset (reset=0, async): state=IDLE. All outputs 0: dec_data=0, flags and counters cleared. Reset mid-job abandons the job without issuing done.
- Byte transfer occurs on a rising edge with in_valid && in_ready. in_ready=1 only in CW0, CW1, B0 and B1.
- Item transfer occurs on a rising edge with dec_data_valid && !dec_busy. dec_data, dec_control_word and dec_data_valid are registered and held stable until the transfer.
- rem counter: loaded with comp_len on start; decremented by 1 on each byte transfer.
- item_idx: 4-bit, 0..15. cw: 16-bit register.
- FSM transitions:
  - IDLE: on start, if comp_len==0 go to FIN; otherwise go to CW0.
  - CW0: on byte transfer, cw[15:8]=byte. If rem==1 before the decrement, set error and go to FIN; otherwise go to CW1.
  - CW1: on byte transfer, cw[7:0]=byte and item_idx=0. If rem==1 before the decrement, go to FIN (control word with no items is legal); otherwise go to B0.
  - B0: flag = cw[15-item_idx] (MSB-first per byte; first byte governs items 0..7). On byte transfer:
    - flag=0: dec_data={8'h00, byte}, dec_control_word=0, go to ISSUE.
    - flag=1: hold byte as high byte. If rem==1 before the decrement, set error and go to FIN; otherwise go to B1.
  - B1: on byte transfer, dec_data={held byte, byte}, dec_control_word=1, go to ISSUE.
  - ISSUE: dec_data_valid=1. On item transfer, drop dec_data_valid the next cycle, then:
    - rem==0: go to FIN.
    - item_idx==15: go to CW0.
    - otherwise: item_idx++ and go to B0.
  - FIN: done=1 for exactly one cycle, then go to IDLE.
- Latency per item: 1 cycle per byte while upstream is valid, plus 1 ISSUE cycle when dec_busy=0. Minimum is 2 cycles per literal and 3 cycles per copy.
- Only one item is ever outstanding. No new byte is accepted while in ISSUE.
- start asserted outside IDLE is ignored and does not disturb the running job.
- dec_busy is not sampled outside ISSUE.

Decomposition:
- Package lzrw1_pkg: state enum (IDLE, CW0, CW1, B0, B1, ISSUE, FIN), CW_BYTES=2, LITERAL_FLAG=1'b0, COPY_FLAG=1'b1, and a function cw_flag(cw, idx) returning cw[15-idx].
- Single module; no sub-module needed.

Test Plan:
- Literal job: start with comp_len=4, bytes 00 00 41 42, dec_busy=0 -> two items issued, {0x0041,cw=0} then {0x0042,cw=0}; done pulses once; error=0.
- Copy item with busy: bytes 40 00 41 F0 03 (comp_len=5), dec_busy held high 5 cycles in ISSUE -> item0 {0x0041,0}, item1 {0xF003,1}; dec_data and dec_data_valid stay stable through all busy cycles; transfer occurs on the first cycle with busy=0.
- Control-word rollover: 18 bytes (cw 0000 followed by 16 literals) plus cw 0000 plus 1 literal, comp_len=21 -> 17 items issued; item_idx wraps to 0; the second control word is consumed.
- Truncation: cw 8000 followed by a single byte, comp_len=3 -> no item issued; error=1; done pulses once. The next start clears error.
- Edge cases: comp_len=0 -> done pulses on the 2nd cycle after start with no in_ready. Upstream in_valid gapped randomly -> item sequence identical to the ungapped run.
- Async reset asserted mid-ISSUE -> all outputs 0 immediately; no done pulse. A new job afterwards runs correctly.
